id_operand_unit: RTL and testbench
==================================

Name: id_operand_unit

Overview:
- Parametrised instruction-decode operand stage for the 5-stage MIPS pipeline; sits between IF and EX.
- Holds the IF/ID pipeline register and keeps the instruction in a skid register during stalls.
- Reads the external regfile and resolves RAW hazards across NUM_FWD forwarding channels plus WB bypass, with load-use stall detection.
- Resolves BEQ/BNE/J/JAL/JR and drives the branch bus to IF.

Parameters:
- NUM_FWD, 2, number of forwarding channels; channel 0 has the highest priority (youngest producer, EX).
- STALL_W, 6, width of the stall bus.

Ports:
- clk  in  1  clock; all state updates on posedge.
- rst  in  1  asynchronous, active-high reset.
- stall  in  STALL_W  bit1 = hold IF/ID, bit2 = hold ID.
- stallreq  out  1  load-use hazard; request a pipeline stall.
- if_valid  in  1  IF slot valid (ce).
- if_pc  in  32  PC of the fetched instruction.
- inst_sram_rdata  in  32  instruction word; arrives one cycle after if_pc is captured.
- rf_raddr1, rf_raddr2  out  5  regfile read addresses (rs, rt).
- rf_rdata1, rf_rdata2  in  32  regfile read data (combinational).
- wb_we, wb_waddr[5], wb_wdata[32]  in  -  writeback bypass.
- fwd_we  in  NUM_FWD  per-channel write enable.
- fwd_waddr  in  5*NUM_FWD  channel k occupies bits [5k+4:5k].
- fwd_wdata  in  32*NUM_FWD  channel k occupies bits [32k+31:32k].
- fwd_rdy  in  NUM_FWD  1 = data valid now; 0 = producer not yet resolved (load).
- id_valid  out  1  ID slot valid toward EX.
- id_pc, id_inst, id_rs_val, id_rt_val  out  32 each  operands to EX.
- br_e  out  1  branch/jump taken.
- br_addr  out  32  branch/jump target.

Behaviour:
- Clock and reset: single clock clk; reset rst asynchronous, active-high.
- Reset:
  - IF/ID register {valid, pc} = 0; skid register inst_hold = 0; hold_vld = 0.
  - Outputs: id_valid = 0, id_pc = 0, br_e = 0, stallreq = 0.
- IF/ID register, evaluated in priority order on posedge:
  - stall[1]=1 and stall[2]=0: load bubble; valid = 0, pc = 0.
  - stall[1]=1 and stall[2]=1: hold current contents.
  - stall[1]=0: load {if_valid, if_pc}.
- Instruction select: inst = hold_vld ? inst_hold : inst_sram_rdata.
- Skid register:
  - When stall[2]=1 and hold_vld=0: capture inst_sram_rdata into inst_hold, set hold_vld = 1.
  - When stall[2]=0: clear hold_vld.
  - A bubble load also clears hold_vld.
- id_inst: inst when valid, else 0.
- Operand use:
  - rs used unless opcode ∈ {J 000010, JAL 000011, LUI 001111}.
  - rt used when opcode = 000000, BEQ 000100, BNE 000101, or opcode[5:3] = 101 (stores).
- Operand resolution per source (rs, rt); the highest-priority match wins:
  1. Address 0 → value 0; never forwarded, never stalls.
  2. Lowest-index channel k with fwd_we[k] and fwd_waddr_k equal to the address → fwd_wdata_k.
  3. wb_we with matching wb_waddr → wb_wdata.
  4. Otherwise rf_rdata.
- stallreq:
  - Asserted when valid, the source is used, and the winning channel k has fwd_rdy[k] = 0.
  - A lower-priority ready channel does NOT override a higher-priority unready match.
  - Combinational.
- Branch unit (br_e = 0 when valid = 0 or stallreq = 1):
  - BEQ: taken if rs_val == rt_val.
  - BNE: taken if rs_val != rt_val.
  - BEQ/BNE target: pc + 4 + sign_ext(imm) << 2.
  - J, JAL: always taken; target {pc_plus4[31:28], instr_index, 2'b00}.
  - JR (opcode 0, func 001000): always taken; target rs_val.
  - br_addr = 0 when br_e = 0.
- Latency: operands and branch are combinational from the registered slot; one register stage from IF.
- Reset mid-stall: slot and skid register clear immediately; no residual stallreq.

Optional Feature:
- Macro ID_PERF_CNT_EN.
- Defined: adds outputs perf_stall_cnt [32] and perf_br_cnt [32].
  - perf_stall_cnt increments every cycle stallreq = 1.
  - perf_br_cnt increments every cycle br_e = 1.
  - Both are async-reset to 0 and wrap from 0xFFFFFFFF to 0.
- Not defined: the ports and counters are absent; all other behaviour is identical.

Test Plan:
- Reset then load pc=0xBFC00000 with inst = addu $3,$1,$2, rf $1=5, $2=7 → id_valid=1, rs_val=5, rt_val=7, br_e=0.
- fwd ch0 (we=1, addr=1, data=0x11, rdy=1) and ch1 (we=1, addr=1, data=0x22) → rs_val=0x11; with ch0 we=0 → rs_val=0x22; with wb addr=1 only → wb_wdata.
- ch0 (we=1, addr=2, rdy=0) with beq $1,$2 → stallreq=1, br_e=0; hold stall[2:1]=11 for 2 cycles while sram data changes → id_inst unchanged; then rdy=1 → stallreq=0, branch resolves.
- inst `ori $0,$0,1` (uses rs=0) with ch0 (we=1, addr=0, rdy=0) → stallreq=0 and rs_val=0 (register 0 never forwarded or stalls).
- pc=0x100: bne with rs_val ≠ rt_val and imm=0xFFFF → br_addr=0x100; jal instr_index=0x40 → br_addr=0x00000100; jr with rs_val=0x80001234 → br_addr=0x80001234.
- stall[2:1]=01 → next cycle id_valid=0, id_pc=0; assert rst mid-stall → skid register and slot clear asynchronously; with ID_PERF_CNT_EN defined, the counters read 0.

Source files
------------

// File: rtl/id_operand_unit_if.sv
// Bus bundle for the ID operand stage: IF slot, regfile, writeback/forwarding and
// the operand/branch outputs toward EX and IF. Stage side uses the slave modport.
interface id_operand_unit_if #(
  parameter int NUM_FWD = 2,
  parameter int STALL_W = 6
);
  logic [STALL_W-1:0]    stall;
  logic                  stallreq;
  logic                  if_valid;
  logic [31:0]           if_pc;
  logic [31:0]           inst_sram_rdata;
  logic [4:0]            rf_raddr1;
  logic [4:0]            rf_raddr2;
  logic [31:0]           rf_rdata1;
  logic [31:0]           rf_rdata2;
  logic                  wb_we;
  logic [4:0]            wb_waddr;
  logic [31:0]           wb_wdata;
  logic [NUM_FWD-1:0]    fwd_we;
  logic [5*NUM_FWD-1:0]  fwd_waddr;
  logic [32*NUM_FWD-1:0] fwd_wdata;
  logic [NUM_FWD-1:0]    fwd_rdy;
  logic                  id_valid;
  logic [31:0]           id_pc;
  logic [31:0]           id_inst;
  logic [31:0]           id_rs_val;
  logic [31:0]           id_rt_val;
  logic                  br_e;
  logic [31:0]           br_addr;

  modport master (
    output stall, if_valid, if_pc, inst_sram_rdata, rf_rdata1, rf_rdata2,
           wb_we, wb_waddr, wb_wdata, fwd_we, fwd_waddr, fwd_wdata, fwd_rdy,
    input  stallreq, rf_raddr1, rf_raddr2, id_valid, id_pc, id_inst,
           id_rs_val, id_rt_val, br_e, br_addr
  );

  modport slave (
    input  stall, if_valid, if_pc, inst_sram_rdata, rf_rdata1, rf_rdata2,
           wb_we, wb_waddr, wb_wdata, fwd_we, fwd_waddr, fwd_wdata, fwd_rdy,
    output stallreq, rf_raddr1, rf_raddr2, id_valid, id_pc, id_inst,
           id_rs_val, id_rt_val, br_e, br_addr
  );
endinterface

// File: rtl/id_operand_unit.sv
// MIPS ID stage: IF/ID register with instruction skid, operand forwarding, load-use
// stall and branch resolution. Define ID_PERF_CNT_EN to add stall/branch counters.
module id_operand_unit #(
  parameter int NUM_FWD = 2,
  parameter int STALL_W = 6
) (
  input  logic              clk,
  input  logic              rst,
  id_operand_unit_if.slave  bus
`ifdef ID_PERF_CNT_EN
  ,
  output logic [31:0]       perf_stall_cnt,
  output logic [31:0]       perf_br_cnt
`endif
);

  localparam logic [5:0] OP_SPECIAL = 6'b000000;
  localparam logic [5:0] OP_J       = 6'b000010;
  localparam logic [5:0] OP_JAL     = 6'b000011;
  localparam logic [5:0] OP_BEQ     = 6'b000100;
  localparam logic [5:0] OP_BNE     = 6'b000101;
  localparam logic [5:0] OP_LUI     = 6'b001111;
  localparam logic [5:0] FN_JR      = 6'b001000;

  logic        valid_q, valid_d;
  logic [31:0] pc_q, pc_d;
  logic [31:0] inst_hold_q, inst_hold_d;
  logic        hold_vld_q, hold_vld_d;

  logic [31:0] inst;
  logic [5:0]  op;
  logic        rs_used, rt_used;
  logic [32:0] rs_res, rt_res;
  logic        stallreq;
  logic        taken;
  logic [31:0] target;
  logic [31:0] pc_plus4;
  logic        unused_stall_bits;

  assign unused_stall_bits = ^{bus.stall[0], bus.stall[STALL_W-1:3]};

  // Returns {pending, value}; descending scan lets the lowest channel index win.
  function automatic logic [32:0] resolve(
    input logic [4:0]             addr,
    input logic [31:0]            rf_val,
    input logic [NUM_FWD-1:0]     we,
    input logic [5*NUM_FWD-1:0]   waddr,
    input logic [32*NUM_FWD-1:0]  wdata,
    input logic [NUM_FWD-1:0]     rdy,
    input logic                   wbwe,
    input logic [4:0]             wbaddr,
    input logic [31:0]            wbdata
  );
    logic [31:0] val;
    logic        pend;
    val  = rf_val;
    pend = 1'b0;
    if (wbwe && wbaddr == addr) val = wbdata;
    for (int k = NUM_FWD - 1; k >= 0; k--) begin
      if (we[k] && waddr[5*k +: 5] == addr) begin
        val  = wdata[32*k +: 32];
        pend = !rdy[k];
      end
    end
    if (addr == 5'd0) begin
      val  = 32'd0;
      pend = 1'b0;
    end
    return {pend, val};
  endfunction

  // NOTE: every variable assigned in an always_comb gets a default first, so no path leaves it latched.
  always_comb begin
    valid_d     = valid_q;
    pc_d        = pc_q;
    inst_hold_d = inst_hold_q;
    hold_vld_d  = hold_vld_q;
    if (bus.stall[1] && !bus.stall[2]) begin
      valid_d = 1'b0;
      pc_d    = 32'd0;
    end else if (!bus.stall[1]) begin
      valid_d = bus.if_valid;
      pc_d    = bus.if_pc;
    end
    if (bus.stall[2] && !hold_vld_q) begin
      inst_hold_d = bus.inst_sram_rdata;
      hold_vld_d  = 1'b1;
    end else if (!bus.stall[2]) begin
      hold_vld_d  = 1'b0;
    end
  end

  // NOTE: sequential state uses non-blocking assignments so all flops sample pre-edge values.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      valid_q     <= 1'b0;
      pc_q        <= 32'd0;
      inst_hold_q <= 32'd0;
      hold_vld_q  <= 1'b0;
    end else begin
      valid_q     <= valid_d;
      pc_q        <= pc_d;
      inst_hold_q <= inst_hold_d;
      hold_vld_q  <= hold_vld_d;
    end
  end

  assign inst     = hold_vld_q ? inst_hold_q : bus.inst_sram_rdata;
  assign op       = inst[31:26];
  assign pc_plus4 = pc_q + 32'd4;

  assign rs_res = resolve(inst[25:21], bus.rf_rdata1, bus.fwd_we, bus.fwd_waddr,
                          bus.fwd_wdata, bus.fwd_rdy, bus.wb_we, bus.wb_waddr, bus.wb_wdata);
  assign rt_res = resolve(inst[20:16], bus.rf_rdata2, bus.fwd_we, bus.fwd_waddr,
                          bus.fwd_wdata, bus.fwd_rdy, bus.wb_we, bus.wb_waddr, bus.wb_wdata);

  always_comb begin
    rs_used  = !(op == OP_J || op == OP_JAL || op == OP_LUI);
    rt_used  = (op == OP_SPECIAL) || (op == OP_BEQ) || (op == OP_BNE) || (op[5:3] == 3'b101);
    stallreq = valid_q && ((rs_used && rs_res[32]) || (rt_used && rt_res[32]));
  end

  always_comb begin
    taken  = 1'b0;
    target = 32'd0;
    unique case (op)
      OP_BEQ, OP_BNE: begin
        taken  = (rs_res[31:0] == rt_res[31:0]) == (op == OP_BEQ);
        target = pc_plus4 + {{14{inst[15]}}, inst[15:0], 2'b00};
      end
      OP_J, OP_JAL: begin
        taken  = 1'b1;
        target = {pc_plus4[31:28], inst[25:0], 2'b00};
      end
      OP_SPECIAL: begin
        taken  = (inst[5:0] == FN_JR);
        target = rs_res[31:0];
      end
      default: ;
    endcase
  end

  assign bus.stallreq  = stallreq;
  assign bus.rf_raddr1 = inst[25:21];
  assign bus.rf_raddr2 = inst[20:16];
  assign bus.id_valid  = valid_q;
  assign bus.id_pc     = pc_q;
  assign bus.id_inst   = valid_q ? inst : 32'd0;
  assign bus.id_rs_val = rs_res[31:0];
  assign bus.id_rt_val = rt_res[31:0];
  assign bus.br_e      = valid_q && !stallreq && taken;
  assign bus.br_addr   = bus.br_e ? target : 32'd0;

`ifdef ID_PERF_CNT_EN
  logic [31:0] stall_cnt_q, stall_cnt_d;
  logic [31:0] br_cnt_q, br_cnt_d;

  always_comb begin
    stall_cnt_d = stallreq ? stall_cnt_q + 32'd1 : stall_cnt_q;
    br_cnt_d    = bus.br_e ? br_cnt_q + 32'd1 : br_cnt_q;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      stall_cnt_q <= 32'd0;
      br_cnt_q    <= 32'd0;
    end else begin
      stall_cnt_q <= stall_cnt_d;
      br_cnt_q    <= br_cnt_d;
    end
  end

  assign perf_stall_cnt = stall_cnt_q;
  assign perf_br_cnt    = br_cnt_q;
`endif

endmodule

// File: tb/tb_id_operand_unit.sv
// Directed table-driven bench for id_operand_unit plus stall, bubble and
// reset-mid-stall sequences.
module tb_id_operand_unit;

  localparam logic [31:0] I_ADDU  = 32'h00221821; // addu $3,$1,$2
  localparam logic [31:0] I_BEQ   = 32'h10220004; // beq $1,$2,+4
  localparam logic [31:0] I_BNE   = 32'h1422FFFF; // bne $1,$2,-1
  localparam logic [31:0] I_ORI0  = 32'h34000001; // ori $0,$0,1
  localparam logic [31:0] I_JAL   = 32'h0C000040;
  localparam logic [31:0] I_J     = 32'h08000040;
  localparam logic [31:0] I_JR    = 32'h00200008; // jr $1
  localparam logic [31:0] I_LUI   = 32'h3C411234; // lui with rs field = 2
  localparam logic [31:0] I_SW    = 32'hAC220000; // sw $2,0($1)
  localparam logic [31:0] I_ADDIU = 32'h24230005; // addiu $3,$1,5

  logic clk = 1'b0;
  logic rst = 1'b1;
  int   total = 0;
  int   bad   = 0;

  always #5 clk = ~clk;

  id_operand_unit_if #(.NUM_FWD(2), .STALL_W(6)) bus ();

`ifdef ID_PERF_CNT_EN
  logic [31:0] perf_stall_cnt, perf_br_cnt;
  id_operand_unit #(.NUM_FWD(2), .STALL_W(6)) dut (
    .clk(clk), .rst(rst), .bus(bus),
    .perf_stall_cnt(perf_stall_cnt), .perf_br_cnt(perf_br_cnt)
  );
`else
  id_operand_unit #(.NUM_FWD(2), .STALL_W(6)) dut (
    .clk(clk), .rst(rst), .bus(bus)
  );
`endif

  typedef struct {
    logic [31:0] pc;
    logic [31:0] inst;
    logic [31:0] rf1;
    logic [31:0] rf2;
    logic [1:0]  we;
    logic [9:0]  waddr;
    logic [63:0] wdata;
    logic [1:0]  rdy;
    logic        wbwe;
    logic [4:0]  wbaddr;
    logic [31:0] wbdata;
    logic [31:0] ers;
    logic [31:0] ert;
    logic        estall;
    logic        ebr;
    logic [31:0] eaddr;
  } vec_t;

  vec_t vecs[$];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic clear_side();
    bus.rf_rdata1 = 32'd0;
    bus.rf_rdata2 = 32'd0;
    bus.wb_we     = 1'b0;
    bus.wb_waddr  = 5'd0;
    bus.wb_wdata  = 32'd0;
    bus.fwd_we    = 2'b00;
    bus.fwd_waddr = 10'd0;
    bus.fwd_wdata = 64'd0;
    bus.fwd_rdy   = 2'b11;
  endtask

  // Load a valid slot with the given PC; instruction data follows one cycle later.
  task automatic load(input logic [31:0] pc);
    bus.stall    = 6'd0;
    bus.if_valid = 1'b1;
    bus.if_pc    = pc;
    @(posedge clk);
    #1;
  endtask

  initial begin
    bus.stall           = 6'd0;
    bus.if_valid        = 1'b1;
    bus.if_pc           = 32'hBFC00000;
    bus.inst_sram_rdata = I_ADDU;
    clear_side();

    // vectors: pc inst rf1 rf2 we waddr wdata rdy wbwe wbaddr wbdata ers ert estall ebr eaddr
    vecs.push_back('{32'hBFC00000, I_ADDU, 32'd5, 32'd7, 2'b00, 10'd0, 64'd0, 2'b11, 1'b0, 5'd0, 32'd0,
                     32'd5, 32'd7, 1'b0, 1'b0, 32'd0});
    vecs.push_back('{32'hBFC00004, I_ADDU, 32'd5, 32'd7, 2'b11, {5'd1, 5'd1}, {32'h22, 32'h11}, 2'b11, 1'b0, 5'd0, 32'd0,
                     32'h11, 32'd7, 1'b0, 1'b0, 32'd0});
    vecs.push_back('{32'hBFC00008, I_ADDU, 32'd5, 32'd7, 2'b10, {5'd1, 5'd1}, {32'h22, 32'h11}, 2'b11, 1'b0, 5'd0, 32'd0,
                     32'h22, 32'd7, 1'b0, 1'b0, 32'd0});
    vecs.push_back('{32'hBFC0000C, I_ADDU, 32'd5, 32'd7, 2'b00, {5'd1, 5'd1}, {32'h22, 32'h11}, 2'b11, 1'b1, 5'd1, 32'h33,
                     32'h33, 32'd7, 1'b0, 1'b0, 32'd0});
    vecs.push_back('{32'hBFC00010, I_ADDU, 32'd5, 32'd7, 2'b10, {5'd1, 5'd1}, {32'h22, 32'h11}, 2'b11, 1'b1, 5'd1, 32'h33,
                     32'h22, 32'd7, 1'b0, 1'b0, 32'd0});
    vecs.push_back('{32'hBFC00014, I_ADDU, 32'd5, 32'd7, 2'b11, {5'd1, 5'd1}, {32'h22, 32'h11}, 2'b10, 1'b0, 5'd0, 32'd0,
                     32'h11, 32'd7, 1'b1, 1'b0, 32'd0});
    vecs.push_back('{32'hBFC00018, I_ADDU, 32'd5, 32'd7, 2'b11, {5'd1, 5'd1}, {32'h22, 32'h11}, 2'b01, 1'b0, 5'd0, 32'd0,
                     32'h11, 32'd7, 1'b0, 1'b0, 32'd0});
    vecs.push_back('{32'hBFC0001C, I_ORI0, 32'hDEADBEEF, 32'hDEADBEEF, 2'b01, 10'd0, {32'h0, 32'h77}, 2'b00, 1'b1, 5'd0, 32'h99,
                     32'd0, 32'd0, 1'b0, 1'b0, 32'd0});
    vecs.push_back('{32'h00000100, I_BNE, 32'd1, 32'd2, 2'b00, 10'd0, 64'd0, 2'b11, 1'b0, 5'd0, 32'd0,
                     32'd1, 32'd2, 1'b0, 1'b1, 32'h00000100});
    vecs.push_back('{32'h00000100, I_BNE, 32'd3, 32'd3, 2'b00, 10'd0, 64'd0, 2'b11, 1'b0, 5'd0, 32'd0,
                     32'd3, 32'd3, 1'b0, 1'b0, 32'd0});
    vecs.push_back('{32'h00000200, I_BEQ, 32'd9, 32'd9, 2'b00, 10'd0, 64'd0, 2'b11, 1'b0, 5'd0, 32'd0,
                     32'd9, 32'd9, 1'b0, 1'b1, 32'h00000214});
    vecs.push_back('{32'h00000200, I_BEQ, 32'd9, 32'd8, 2'b00, 10'd0, 64'd0, 2'b11, 1'b0, 5'd0, 32'd0,
                     32'd9, 32'd8, 1'b0, 1'b0, 32'd0});
    vecs.push_back('{32'h00000100, I_JAL, 32'hAAAA, 32'hBBBB, 2'b00, 10'd0, 64'd0, 2'b11, 1'b0, 5'd0, 32'd0,
                     32'd0, 32'd0, 1'b0, 1'b1, 32'h00000100});
    vecs.push_back('{32'h90000000, I_J, 32'd0, 32'd0, 2'b00, 10'd0, 64'd0, 2'b11, 1'b0, 5'd0, 32'd0,
                     32'd0, 32'd0, 1'b0, 1'b1, 32'h90000100});
    vecs.push_back('{32'h00000300, I_JR, 32'h80001234, 32'hBBBB, 2'b00, 10'd0, 64'd0, 2'b11, 1'b0, 5'd0, 32'd0,
                     32'h80001234, 32'd0, 1'b0, 1'b1, 32'h80001234});
    vecs.push_back('{32'h00000300, I_JR, 32'h80001234, 32'd0, 2'b01, {5'd0, 5'd1}, {32'h0, 32'h11}, 2'b00, 1'b0, 5'd0, 32'd0,
                     32'h11, 32'd0, 1'b1, 1'b0, 32'd0});
    vecs.push_back('{32'h00000400, I_LUI, 32'd4, 32'd6, 2'b01, {5'd0, 5'd2}, {32'h0, 32'h55}, 2'b00, 1'b0, 5'd0, 32'd0,
                     32'h55, 32'd6, 1'b0, 1'b0, 32'd0});
    vecs.push_back('{32'h00000404, I_SW, 32'd4, 32'd6, 2'b01, {5'd0, 5'd2}, {32'h0, 32'h55}, 2'b00, 1'b0, 5'd0, 32'd0,
                     32'd4, 32'h55, 1'b1, 1'b0, 32'd0});
    vecs.push_back('{32'h00000408, I_ADDIU, 32'd4, 32'd6, 2'b01, {5'd0, 5'd3}, {32'h0, 32'h55}, 2'b00, 1'b0, 5'd0, 32'd0,
                     32'd4, 32'h55, 1'b0, 1'b0, 32'd0});
    vecs.push_back('{32'h00000200, I_BEQ, 32'd9, 32'd0, 2'b00, 10'd0, 64'd0, 2'b11, 1'b1, 5'd2, 32'd9,
                     32'd9, 32'd9, 1'b0, 1'b1, 32'h00000214});

    // Reset holds the slot empty even with a valid fetch presented.
    repeat (2) @(posedge clk);
    #1;
    check("rst_id_valid", {31'd0, bus.id_valid}, 32'd0);
    check("rst_id_pc", bus.id_pc, 32'd0);
    check("rst_br_e", {31'd0, bus.br_e}, 32'd0);
    check("rst_stallreq", {31'd0, bus.stallreq}, 32'd0);
`ifdef ID_PERF_CNT_EN
    check("rst_perf_stall", perf_stall_cnt, 32'd0);
    check("rst_perf_br", perf_br_cnt, 32'd0);
`endif
    #2 rst = 1'b0;

    foreach (vecs[i]) begin
      clear_side();
      load(vecs[i].pc);
      bus.inst_sram_rdata = vecs[i].inst;
      bus.rf_rdata1       = vecs[i].rf1;
      bus.rf_rdata2       = vecs[i].rf2;
      bus.fwd_we          = vecs[i].we;
      bus.fwd_waddr       = vecs[i].waddr;
      bus.fwd_wdata       = vecs[i].wdata;
      bus.fwd_rdy         = vecs[i].rdy;
      bus.wb_we           = vecs[i].wbwe;
      bus.wb_waddr        = vecs[i].wbaddr;
      bus.wb_wdata        = vecs[i].wbdata;
      #1;
      check($sformatf("v%0d_id_valid", i), {31'd0, bus.id_valid}, 32'd1);
      check($sformatf("v%0d_id_pc", i), bus.id_pc, vecs[i].pc);
      check($sformatf("v%0d_id_inst", i), bus.id_inst, vecs[i].inst);
      check($sformatf("v%0d_raddr1", i), {27'd0, bus.rf_raddr1}, {27'd0, vecs[i].inst[25:21]});
      check($sformatf("v%0d_raddr2", i), {27'd0, bus.rf_raddr2}, {27'd0, vecs[i].inst[20:16]});
      check($sformatf("v%0d_rs_val", i), bus.id_rs_val, vecs[i].ers);
      check($sformatf("v%0d_rt_val", i), bus.id_rt_val, vecs[i].ert);
      check($sformatf("v%0d_stallreq", i), {31'd0, bus.stallreq}, {31'd0, vecs[i].estall});
      check($sformatf("v%0d_br_e", i), {31'd0, bus.br_e}, {31'd0, vecs[i].ebr});
      check($sformatf("v%0d_br_addr", i), bus.br_addr, vecs[i].eaddr);
    end

    // Load-use stall on beq, held two cycles while the SRAM word changes.
    clear_side();
    load(32'h00000200);
    bus.inst_sram_rdata = I_BEQ;
    bus.rf_rdata1       = 32'd9;
    bus.fwd_we          = 2'b01;
    bus.fwd_waddr       = {5'd0, 5'd2};
    bus.fwd_wdata       = {32'h0, 32'd9};
    bus.fwd_rdy         = 2'b00;
    #1;
    check("lu_stallreq", {31'd0, bus.stallreq}, 32'd1);
    check("lu_br_e", {31'd0, bus.br_e}, 32'd0);
    bus.stall = 6'b000110;
    bus.if_pc = 32'h00000BAD;
    @(posedge clk);
    #1;
    bus.inst_sram_rdata = 32'hFFFFFFFF;
    @(posedge clk);
    #1;
    check("hold_id_inst", bus.id_inst, I_BEQ);
    check("hold_id_pc", bus.id_pc, 32'h00000200);
    check("hold_id_valid", {31'd0, bus.id_valid}, 32'd1);
    check("hold_stallreq", {31'd0, bus.stallreq}, 32'd1);
    bus.fwd_rdy = 2'b01;
    #1;
    check("rdy_stallreq", {31'd0, bus.stallreq}, 32'd0);
    check("rdy_br_e", {31'd0, bus.br_e}, 32'd1);
    check("rdy_br_addr", bus.br_addr, 32'h00000214);
    check("rdy_rt_val", bus.id_rt_val, 32'd9);

    // Bubble load: stall[1] without stall[2] empties the slot.
    bus.stall           = 6'b000010;
    bus.inst_sram_rdata = I_JR;
    bus.fwd_waddr       = {5'd0, 5'd1};
    bus.fwd_rdy         = 2'b00;
    @(posedge clk);
    #1;
    check("bub_id_valid", {31'd0, bus.id_valid}, 32'd0);
    check("bub_id_pc", bus.id_pc, 32'd0);
    check("bub_id_inst", bus.id_inst, 32'd0);
    check("bub_br_e", {31'd0, bus.br_e}, 32'd0);
    check("bub_stallreq", {31'd0, bus.stallreq}, 32'd0);

    // Reset asserted mid-stall clears slot and skid without waiting for an edge.
    clear_side();
    load(32'h00000500);
    bus.inst_sram_rdata = I_BEQ;
    bus.fwd_we          = 2'b01;
    bus.fwd_waddr       = {5'd0, 5'd2};
    bus.fwd_rdy         = 2'b00;
    bus.stall           = 6'b000110;
    @(posedge clk);
    #1;
    bus.inst_sram_rdata = I_ADDU;
    #1;
    check("pre_rst_skid_inst", bus.id_inst, I_BEQ);
    check("pre_rst_stallreq", {31'd0, bus.stallreq}, 32'd1);
    #1 rst = 1'b1;
    #1;
    check("mid_rst_id_valid", {31'd0, bus.id_valid}, 32'd0);
    check("mid_rst_id_pc", bus.id_pc, 32'd0);
    check("mid_rst_id_inst", bus.id_inst, 32'd0);
    check("mid_rst_stallreq", {31'd0, bus.stallreq}, 32'd0);
    check("mid_rst_br_e", {31'd0, bus.br_e}, 32'd0);
`ifdef ID_PERF_CNT_EN
    check("mid_rst_perf_stall", perf_stall_cnt, 32'd0);
    check("mid_rst_perf_br", perf_br_cnt, 32'd0);
`endif
    @(posedge clk);
    #2 rst = 1'b0;

    // Fresh stall after reset must capture the current word, not the stale skid.
    clear_side();
    bus.stall           = 6'b000100;
    bus.if_valid        = 1'b1;
    bus.if_pc           = 32'h00000600;
    bus.inst_sram_rdata = I_ADDU;
    @(posedge clk);
    #1;
    bus.stall = 6'b000110;
    @(posedge clk);
    #1;
    bus.inst_sram_rdata = 32'h0;
    #1;
    check("post_rst_id_pc", bus.id_pc, 32'h00000600);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
